// File: rtl/cpu_cmd_dispatcher.sv
// +--------------------------------------------------------------------------+
// | cpu_cmd_dispatcher: host command FIFO and one-at-a-time CPU issue FSM.   |
// | Optional watchdog: define DISPATCH_TIMEOUT_EN.  Revision: 1.0            |
// +--------------------------------------------------------------------------+
`default_nettype none

module cpu_cmd_dispatcher #(
  parameter int CMD_W   = 7,
  parameter int DEPTH   = 8,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  input  logic [CMD_W-1:0]         cmd_data,
  output logic                     cmd_ready,
  input  logic                     flush,
  input  logic                     clear_halt,
  input  logic                     cpu_rdy,
  input  logic                     zero_in,
  input  logic                     error_in,
  output logic [CMD_W-1:0]         cpu_cmd,
  output logic                     cpu_cmd_load,
  output logic                     busy,
  output logic                     halted,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     last_zero,
  output logic                     last_error,
  output logic [CNT_W-1:0]         done_count,
  output logic [CNT_W-1:0]         err_count
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_ISSUE      = 3'd1;
  localparam logic [2:0] S_WAIT_START = 3'd2;
  localparam logic [2:0] S_WAIT_DONE  = 3'd3;
  localparam logic [2:0] S_CHECK      = 3'd4;
  localparam logic [2:0] S_HALT       = 3'd5;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_params
    $error("cpu_cmd_dispatcher: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
  end

  logic [2:0]       r_state, w_next;
  logic [CMD_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_full, w_push, w_pop, w_check_err, w_expire;

  assign w_full     = (r_count == (AW+1)'(DEPTH));
  assign cmd_ready  = !w_full;
  assign fifo_count = r_count;
  assign w_push     = cmd_valid && !w_full && !flush;
  // Guarded so a flush just before ISSUE cannot underflow the count.
  assign w_pop      = (r_state == S_ISSUE) && (r_count != '0);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= cmd_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= r_wr_ptr;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef DISPATCH_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] r_wdog;
  logic            r_timed_out;

  assign w_expire    = (r_wdog == WD_W'(TIMEOUT - 1));
  assign w_check_err = error_in || r_timed_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wdog      <= '0;
      r_timed_out <= 1'b0;
    end else begin
      r_timed_out <= w_expire && ((r_state == S_WAIT_START && cpu_rdy) ||
                                  (r_state == S_WAIT_DONE  && !cpu_rdy));
      if (r_state == S_ISSUE || (r_state == S_WAIT_START && !cpu_rdy))
        r_wdog <= '0;
      else if (r_state == S_WAIT_START || r_state == S_WAIT_DONE)
        r_wdog <= r_wdog + 1'b1;
    end
  end
`else
  assign w_expire    = 1'b0;
  assign w_check_err = error_in;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:       if (r_count != '0 && cpu_rdy) w_next = S_ISSUE;
      S_ISSUE:      w_next = S_WAIT_START;
      S_WAIT_START: if (!cpu_rdy) w_next = S_WAIT_DONE;
                    else if (w_expire) w_next = S_CHECK;
      S_WAIT_DONE:  if (cpu_rdy || w_expire) w_next = S_CHECK;
      S_CHECK:      w_next = w_check_err ? S_HALT : S_IDLE;
      S_HALT:       if (clear_halt) w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

  always_comb begin
    cpu_cmd_load = (r_state == S_ISSUE);
    halted       = (r_state == S_HALT);
    busy         = (r_state == S_ISSUE) || (r_state == S_WAIT_START) ||
                   (r_state == S_WAIT_DONE) || (r_state == S_CHECK);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_cmd    <= '0;
      last_zero  <= 1'b0;
      last_error <= 1'b0;
      done_count <= '0;
      err_count  <= '0;
    end else begin
      if (r_state == S_IDLE && w_next == S_ISSUE) cpu_cmd <= r_mem[r_rd_ptr];
      if (r_state == S_CHECK) begin
        last_zero  <= zero_in;
        last_error <= w_check_err;
        if (done_count != '1) done_count <= done_count + 1'b1;
        if (w_check_err && err_count != '1) err_count <= err_count + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cpu_cmd_dispatcher.sv
// +--------------------------------------------------------------------------+
// | tb_cpu_cmd_dispatcher: scoreboard bench with a handshaking CPU model.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_cpu_cmd_dispatcher;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [6:0] cmd_data = '0;
  logic       cmd_ready;
  logic       flush = 1'b0;
  logic       clear_halt = 1'b0;
  logic       cpu_rdy, zero_in, error_in;
  logic [6:0] cpu_cmd;
  logic       cpu_cmd_load, busy, halted;
  logic [3:0] fifo_count;
  logic       last_zero, last_error;
  logic [7:0] done_count, err_count;

  int         checks = 0;
  int         errors = 0;
  int         issue_cnt = 0;
  logic [6:0] exp_q[$];
  logic       cpu_hold = 1'b0;
  logic [6:0] err_cmd = 7'h13;

  always #5 clk = ~clk;

  cpu_cmd_dispatcher dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready), .flush(flush), .clear_halt(clear_halt),
    .cpu_rdy(cpu_rdy), .zero_in(zero_in), .error_in(error_in),
    .cpu_cmd(cpu_cmd), .cpu_cmd_load(cpu_cmd_load), .busy(busy),
    .halted(halted), .fifo_count(fifo_count), .last_zero(last_zero),
    .last_error(last_error), .done_count(done_count), .err_count(err_count)
  );

  // CPU model: drops rdy 2 cycles after a load, raises it 3 cycles later
  initial begin : cpu_model
    logic err_now, zero_now;
    cpu_rdy = 1'b1; zero_in = 1'b0; error_in = 1'b0;
    forever begin
      @(negedge clk);
      if (cpu_cmd_load === 1'b1) begin
        err_now  = (cpu_cmd == err_cmd);
        zero_now = ~cpu_cmd[0];
        repeat (2) @(posedge clk);
        #1 cpu_rdy = 1'b0; error_in = 1'b0; zero_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 cpu_rdy = 1'b1; error_in = err_now; zero_in = zero_now;
      end else begin
        cpu_rdy = !cpu_hold;
      end
    end
  end

  always @(negedge clk) begin : issue_monitor
    logic [6:0] exp_c;
    if (cpu_cmd_load === 1'b1) begin
      issue_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL issue_order: got unexpected issue cpu_cmd=%h, expected no issue", cpu_cmd);
      end else begin
        exp_c = exp_q.pop_front();
        if (cpu_cmd !== exp_c) begin
          errors++;
          $display("FAIL issue_order: got cpu_cmd=%h, expected %h", cpu_cmd, exp_c);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [6:0] d, input bit accept);
    cmd_valid = 1'b1;
    cmd_data  = d;
    if (accept) exp_q.push_back(d);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    @(negedge clk);
    while ((busy !== 1'b0 || fifo_count !== 4'd0) && n < max) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= max) begin
      errors++;
      $display("FAIL wait_idle: got busy=%b fifo_count=%0d, expected idle within %0d cycles", busy, fifo_count, max);
    end
    tick();
  endtask

  task automatic wait_rdy_low(input int max);
    int n = 0;
    @(negedge clk);
    while (cpu_rdy !== 1'b0 && n < max) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= max) begin
      errors++;
      $display("FAIL wait_rdy_low: got cpu_rdy=%b, expected 0 within %0d cycles", cpu_rdy, max);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 4;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b, expected 1", cmd_ready); end
    if ({busy, halted, cpu_cmd_load} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b, expected 000", {busy, halted, cpu_cmd_load}); end
    if (fifo_count !== 4'd0 || cpu_cmd !== 7'h00) begin errors++; $display("FAIL reset_fifo: got count=%0d cmd=%h, expected 0/00", fifo_count, cpu_cmd); end
    if ({done_count, err_count, last_zero, last_error} !== 18'd0) begin errors++; $display("FAIL reset_counters: got %h, expected 0", {done_count, err_count, last_zero, last_error}); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    push(7'h05, 1'b1);
    wait_idle(50);
    checks += 4;
    if (done_count !== 8'd1) begin errors++; $display("FAIL single_done: got %0d, expected 1", done_count); end
    if (last_error !== 1'b0 || last_zero !== 1'b0) begin errors++; $display("FAIL single_flags: got zero=%b err=%b, expected 0/0", last_zero, last_error); end
    if (issue_cnt !== 1) begin errors++; $display("FAIL single_issues: got %0d, expected 1", issue_cnt); end
    if (fifo_count !== 4'd0 || busy !== 1'b0) begin errors++; $display("FAIL single_idle: got count=%0d busy=%b, expected 0/0", fifo_count, busy); end
  endtask

  task automatic test_fill();
    cpu_hold = 1'b1;
    @(negedge clk);
    tick();
    for (int i = 1; i <= 8; i++) push(7'(i), 1'b1);
    checks += 2;
    if (fifo_count !== 4'd8) begin errors++; $display("FAIL fill_count: got %0d, expected 8", fifo_count); end
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL fill_ready: got %b, expected 0", cmd_ready); end
    push(7'h09, 1'b0);
    checks++;
    if (fifo_count !== 4'd8) begin errors++; $display("FAIL fill_drop: got %0d, expected 8", fifo_count); end
    cpu_hold = 1'b0;
    wait_idle(200);
    checks += 2;
    if (done_count !== 8'd9 || issue_cnt !== 9) begin errors++; $display("FAIL fill_done: got done=%0d issues=%0d, expected 9/9", done_count, issue_cnt); end
    if (last_zero !== 1'b1) begin errors++; $display("FAIL fill_zero: got %b, expected 1", last_zero); end
  endtask

  task automatic test_error_halt();
    int n = 0;
    int issues_at_halt;
    cpu_hold = 1'b1;
    @(negedge clk);
    tick();
    for (int i = 1; i <= 5; i++) push(7'h10 + 7'(i), 1'b1);
    cpu_hold = 1'b0;
    while (halted !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks += 4;
    if (halted !== 1'b1) begin errors++; $display("FAIL halt_enter: got halted=%b, expected 1", halted); end
    if (err_count !== 8'd1 || last_error !== 1'b1) begin errors++; $display("FAIL halt_err: got err=%0d last=%b, expected 1/1", err_count, last_error); end
    if (fifo_count !== 4'd2) begin errors++; $display("FAIL halt_queue: got %0d, expected 2", fifo_count); end
    if (done_count !== 8'd12) begin errors++; $display("FAIL halt_done: got %0d, expected 12", done_count); end
    issues_at_halt = issue_cnt;
    repeat (10) @(negedge clk);
    checks++;
    if (issue_cnt !== issues_at_halt || halted !== 1'b1) begin errors++; $display("FAIL halt_hold: got issues=%0d halted=%b, expected %0d/1", issue_cnt, halted, issues_at_halt); end
    tick();
    clear_halt = 1'b1;
    tick();
    clear_halt = 1'b0;
    wait_idle(100);
    checks += 2;
    if (done_count !== 8'd14 || err_count !== 8'd1) begin errors++; $display("FAIL resume_counts: got done=%0d err=%0d, expected 14/1", done_count, err_count); end
    if (halted !== 1'b0 || last_error !== 1'b0 || last_zero !== 1'b0) begin errors++; $display("FAIL resume_flags: got h=%b e=%b z=%b, expected 0/0/0", halted, last_error, last_zero); end
  endtask

  task automatic test_push_pop_flush();
    int n = 0;
    cpu_hold = 1'b1;
    @(negedge clk);
    tick();
    push(7'h21, 1'b1); push(7'h22, 1'b1); push(7'h23, 1'b1);
    checks++;
    if (fifo_count !== 4'd3) begin errors++; $display("FAIL pp_pre: got %0d, expected 3", fifo_count); end
    cpu_hold = 1'b0;
    @(negedge clk);
    while (cpu_cmd_load !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    cmd_valid = 1'b1;
    cmd_data  = 7'h24;
    exp_q.push_back(7'h24);
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (fifo_count !== 4'd3) begin errors++; $display("FAIL pp_same_cycle: got %0d, expected 3", fifo_count); end
    wait_rdy_low(20);
    tick();
    flush     = 1'b1;
    cmd_valid = 1'b1;
    cmd_data  = 7'h2F;
    tick();
    flush     = 1'b0;
    cmd_valid = 1'b0;
    exp_q.delete();
    checks += 2;
    if (fifo_count !== 4'd0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL flush_count: got count=%0d ready=%b, expected 0/1", fifo_count, cmd_ready); end
    if (busy !== 1'b1) begin errors++; $display("FAIL flush_inflight: got busy=%b, expected 1", busy); end
    wait_idle(50);
    checks++;
    if (done_count !== 8'd15 || issue_cnt !== 15) begin errors++; $display("FAIL flush_done: got done=%0d issues=%0d, expected 15/15", done_count, issue_cnt); end
  endtask

  task automatic test_reset_mid();
    push(7'h31, 1'b1);
    push(7'h32, 1'b1);
    wait_rdy_low(20);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    exp_q.delete();
    checks += 3;
    if (busy !== 1'b0 || halted !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_flags: got busy=%b halted=%b ready=%b, expected 0/0/1", busy, halted, cmd_ready); end
    if (fifo_count !== 4'd0 || cpu_cmd !== 7'h00) begin errors++; $display("FAIL rst_mid_fifo: got count=%0d cmd=%h, expected 0/00", fifo_count, cpu_cmd); end
    if ({done_count, err_count, last_zero, last_error} !== 18'd0) begin errors++; $display("FAIL rst_mid_counters: got %h, expected 0", {done_count, err_count, last_zero, last_error}); end
    tick();
    reset = 1'b0;
    repeat (8) tick();
    push(7'h40, 1'b1);
    wait_idle(50);
    checks++;
    if (done_count !== 8'd1 || last_zero !== 1'b1) begin errors++; $display("FAIL rst_mid_after: got done=%0d zero=%b, expected 1/1", done_count, last_zero); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_error_halt();
    test_push_pop_flush();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
